mshr_noc_arb: RTL and testbench

Multi-outstanding successor to the single-transaction MSHR NoC unit: arbitrates `SOURCE_NUM` MSHR request ports onto one `mem_req_if` sink with round-robin fairness and keeps up to `MAX_OUTSTANDING` requests in flight. Each atomic response is routed back to its originating source by `mshrid` lookup in a small tag table. Sits between the per-tile MSHR units and the NoC encoder in the DCP/cohort memory path.

---
 rtl/mshr_noc_arb.sv | 215 +++++++++++++++++++++
 tb/tb_mshr_noc_arb.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mshr_noc_arb.sv
// Round-robin arbiter from MSHR request ports onto one memory request sink.
// A tag table tracks in-flight mshrids and routes atomic responses back to their sources.
module mshr_noc_arb #(
  parameter int SOURCE_NUM      = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int REQ_TYPE_W      = 4,
  parameter int MSHRID_W        = 8,
  parameter int ADDR_W          = 40,
  parameter int SIZE_W          = 3,
  parameter int HOMEID_W        = 16,
  parameter int WMASK_W         = 8,
  parameter int DATA_W          = 64,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic [SOURCE_NUM-1:0] mem_req_source_valid,
  output logic [SOURCE_NUM-1:0] mem_req_source_ready,
  input  logic [REQ_TYPE_W-1:0] mem_req_source_req_type   [SOURCE_NUM],
  input  logic [MSHRID_W-1:0]   mem_req_source_mshrid     [SOURCE_NUM],
  input  logic [ADDR_W-1:0]     mem_req_source_address    [SOURCE_NUM],
  input  logic [SIZE_W-1:0]     mem_req_source_size       [SOURCE_NUM],
  input  logic [HOMEID_W-1:0]   mem_req_source_homeid     [SOURCE_NUM],
  input  logic [WMASK_W-1:0]    mem_req_source_write_mask [SOURCE_NUM],
  input  logic [DATA_W-1:0]     mem_req_source_data_0     [SOURCE_NUM],
  input  logic [DATA_W-1:0]     mem_req_source_data_1     [SOURCE_NUM],

  output logic                  mem_req_sink_valid,
  input  logic                  mem_req_sink_ready,
  output logic [REQ_TYPE_W-1:0] mem_req_sink_req_type,
  output logic [MSHRID_W-1:0]   mem_req_sink_mshrid,
  output logic [ADDR_W-1:0]     mem_req_sink_address,
  output logic [SIZE_W-1:0]     mem_req_sink_size,
  output logic [HOMEID_W-1:0]   mem_req_sink_homeid,
  output logic [WMASK_W-1:0]    mem_req_sink_write_mask,
  output logic [DATA_W-1:0]     mem_req_sink_data_0,
  output logic [DATA_W-1:0]     mem_req_sink_data_1,

  input  logic                  atomic_resp_source_valid,
  input  logic [MSHRID_W-1:0]   atomic_resp_source_mshrid,
  input  logic [DATA_W-1:0]     atomic_resp_source_data,

  output logic [SOURCE_NUM-1:0] atomic_resp_sink_valid,
  output logic [MSHRID_W-1:0]   atomic_resp_sink_mshrid   [SOURCE_NUM],
  output logic [DATA_W-1:0]     atomic_resp_sink_data     [SOURCE_NUM],

  output logic [CNT_W-1:0]      outstanding_cnt,
  output logic                  resp_orphan
);

  localparam int SRC_W = $clog2(SOURCE_NUM);
  localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

  logic [MAX_OUTSTANDING-1:0] tbl_vld;
  logic [MSHRID_W-1:0]        tbl_mshrid [MAX_OUTSTANDING];
  logic [SRC_W-1:0]           tbl_src    [MAX_OUTSTANDING];

  lock_state_e                lock_state;
  logic [SRC_W-1:0]           lock_idx;
  logic [SRC_W-1:0]           last_grant;
  logic [SRC_W-1:0]           grant;
  logic [SRC_W-1:0]           rr_idx;
  logic                       rr_found;
  int                         cand;

  logic                       full;
  logic [SOURCE_NUM-1:0]      dup;
  logic [SOURCE_NUM-1:0]      eligible;
  logic                       handshake;

  logic [IDX_W-1:0]           alloc_idx;
  logic                       alloc_found;
  logic [MAX_OUTSTANDING-1:0] resp_hit;
  logic                       resp_free;

  // Full and duplicate checks look only at registered state, so a slot freed this cycle is not reusable yet.
  assign full = &tbl_vld;

  always_comb begin
    dup      = '0;
    eligible = '0;
    for (int i = 0; i < SOURCE_NUM; i++) begin
      for (int e = 0; e < MAX_OUTSTANDING; e++) begin
        if (tbl_vld[e] && (tbl_mshrid[e] == mem_req_source_mshrid[i])) dup[i] = 1'b1;
      end
      eligible[i] = mem_req_source_valid[i] && !full && !dup[i];
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = 0;
    for (int k = 1; k <= SOURCE_NUM; k++) begin
      cand = (int'(last_grant) + k) % SOURCE_NUM;
      if (!rr_found && eligible[SRC_W'(cand)]) begin
        rr_found = 1'b1;
        rr_idx   = SRC_W'(cand);
      end
    end
  end

  assign grant              = (lock_state == LOCKED) ? lock_idx : rr_idx;
  assign mem_req_sink_valid = (lock_state == LOCKED) ? eligible[lock_idx] : rr_found;
  assign handshake          = mem_req_sink_valid && mem_req_sink_ready;

  assign mem_req_sink_req_type   = mem_req_source_req_type[grant];
  assign mem_req_sink_mshrid     = mem_req_source_mshrid[grant];
  assign mem_req_sink_address    = mem_req_source_address[grant];
  assign mem_req_sink_size       = mem_req_source_size[grant];
  assign mem_req_sink_homeid     = mem_req_source_homeid[grant];
  assign mem_req_sink_write_mask = mem_req_source_write_mask[grant];
  assign mem_req_sink_data_0     = mem_req_source_data_0[grant];
  assign mem_req_sink_data_1     = mem_req_source_data_1[grant];

  always_comb begin
    mem_req_source_ready = '0;
    for (int i = 0; i < SOURCE_NUM; i++) begin
      mem_req_source_ready[i] = handshake && (grant == SRC_W'(i));
    end
  end

  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    for (int e = 0; e < MAX_OUTSTANDING; e++) begin
      if (!alloc_found && !tbl_vld[e]) begin
        alloc_found = 1'b1;
        alloc_idx   = IDX_W'(e);
      end
    end
  end

  // Tags in the table are unique, so at most one entry can hit.
  always_comb begin
    resp_hit               = '0;
    atomic_resp_sink_valid = '0;
    for (int e = 0; e < MAX_OUTSTANDING; e++) begin
      if (atomic_resp_source_valid && tbl_vld[e] && (tbl_mshrid[e] == atomic_resp_source_mshrid)) begin
        resp_hit[e]                        = 1'b1;
        atomic_resp_sink_valid[tbl_src[e]] = 1'b1;
      end
    end
  end

  assign resp_free   = |resp_hit;
  assign resp_orphan = atomic_resp_source_valid && !resp_free;

  for (genvar i = 0; i < SOURCE_NUM; i++) begin : g_resp_bcast
    assign atomic_resp_sink_mshrid[i] = atomic_resp_source_mshrid;
    assign atomic_resp_sink_data[i]   = atomic_resp_source_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_vld <= '0;
      for (int e = 0; e < MAX_OUTSTANDING; e++) begin
        tbl_mshrid[e] <= '0;
        tbl_src[e]    <= '0;
      end
    end else begin
      for (int e = 0; e < MAX_OUTSTANDING; e++) begin
        if (resp_hit[e]) tbl_vld[e] <= 1'b0;
        if (handshake && alloc_found && (alloc_idx == IDX_W'(e))) begin
          tbl_vld[e]    <= 1'b1;
          tbl_mshrid[e] <= mem_req_sink_mshrid;
          tbl_src[e]    <= grant;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_cnt <= '0;
    end else begin
      case ({handshake, resp_free})
        2'b10:   outstanding_cnt <= outstanding_cnt + CNT_W'(1);
        2'b01:   outstanding_cnt <= outstanding_cnt - CNT_W'(1);
        default: outstanding_cnt <= outstanding_cnt;
      endcase
    end
  end

  // Grant lock: hold the index while the sink is stalled so the payload cannot switch mid-transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_state <= UNLOCKED;
      lock_idx   <= '0;
      last_grant <= SRC_W'(SOURCE_NUM - 1);
    end else begin
      case (lock_state)
        UNLOCKED: begin
          if (handshake) begin
            last_grant <= grant;
          end else if (mem_req_sink_valid) begin
            lock_state <= LOCKED;
            lock_idx   <= grant;
          end
        end
        LOCKED: begin
          if (handshake) begin
            lock_state <= UNLOCKED;
            last_grant <= grant;
          end
        end
        default: lock_state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_mshr_noc_arb.sv
// Directed scenarios plus randomized traffic checked against a tag-map reference model.
module tb_mshr_noc_arb;
  localparam int NS = 4;
  localparam int MO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS-1:0] src_valid, src_ready;
  logic [3:0]    src_req_type [NS];
  logic [7:0]    src_mshrid   [NS];
  logic [39:0]   src_address  [NS];
  logic [2:0]    src_size     [NS];
  logic [15:0]   src_homeid   [NS];
  logic [7:0]    src_wmask    [NS];
  logic [63:0]   src_d0       [NS];
  logic [63:0]   src_d1       [NS];

  logic          sink_valid, sink_ready;
  logic [3:0]    sink_req_type;
  logic [7:0]    sink_mshrid;
  logic [39:0]   sink_address;
  logic [2:0]    sink_size;
  logic [15:0]   sink_homeid;
  logic [7:0]    sink_wmask;
  logic [63:0]   sink_d0, sink_d1;

  logic          resp_valid;
  logic [7:0]    resp_mshrid;
  logic [63:0]   resp_data;
  logic [NS-1:0] rsink_valid;
  logic [7:0]    rsink_mshrid [NS];
  logic [63:0]   rsink_data   [NS];
  logic [2:0]    cnt;
  logic          orphan;

  mshr_noc_arb dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req_source_valid(src_valid), .mem_req_source_ready(src_ready),
    .mem_req_source_req_type(src_req_type), .mem_req_source_mshrid(src_mshrid),
    .mem_req_source_address(src_address), .mem_req_source_size(src_size),
    .mem_req_source_homeid(src_homeid), .mem_req_source_write_mask(src_wmask),
    .mem_req_source_data_0(src_d0), .mem_req_source_data_1(src_d1),
    .mem_req_sink_valid(sink_valid), .mem_req_sink_ready(sink_ready),
    .mem_req_sink_req_type(sink_req_type), .mem_req_sink_mshrid(sink_mshrid),
    .mem_req_sink_address(sink_address), .mem_req_sink_size(sink_size),
    .mem_req_sink_homeid(sink_homeid), .mem_req_sink_write_mask(sink_wmask),
    .mem_req_sink_data_0(sink_d0), .mem_req_sink_data_1(sink_d1),
    .atomic_resp_source_valid(resp_valid), .atomic_resp_source_mshrid(resp_mshrid),
    .atomic_resp_source_data(resp_data),
    .atomic_resp_sink_valid(rsink_valid), .atomic_resp_sink_mshrid(rsink_mshrid),
    .atomic_resp_sink_data(rsink_data),
    .outstanding_cnt(cnt), .resp_orphan(orphan)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: map of in-flight mshrid -> owning source, plus round-robin pointer and lock.
  int owner [int];
  int m_last;
  bit m_locked;
  int m_lock_src;
  int hs_src;
  int dut_hs;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner.delete();
    m_last     = NS - 1;
    m_locked   = 1'b0;
    m_lock_src = 0;
  endtask

  function automatic bit elig(input int i);
    return src_valid[i] && (owner.num() < MO) && !owner.exists(int'(src_mshrid[i]));
  endfunction

  task automatic cycle();
    int g;
    bit ev;
    logic [NS-1:0] exp_rdy, exp_rv;
    bit exp_orph;
    int rkey;
    #1;
    g = -1;
    if (m_locked) begin
      if (elig(m_lock_src)) g = m_lock_src;
    end else begin
      for (int k = 1; k <= NS; k++) begin
        int c;
        c = (m_last + k) % NS;
        if (g < 0 && elig(c)) g = c;
      end
    end
    ev = (g >= 0);
    chk("sink_valid", 64'(sink_valid), 64'(ev));
    if (ev) begin
      chk("sink_mshrid", 64'(sink_mshrid), 64'(src_mshrid[g]));
      chk("sink_address", 64'(sink_address), 64'(src_address[g]));
      chk("sink_data_0", sink_d0, src_d0[g]);
      chk("sink_homeid", 64'(sink_homeid), 64'(src_homeid[g]));
    end
    exp_rdy = '0;
    if (ev && sink_ready) exp_rdy[g] = 1'b1;
    chk("src_ready", 64'(src_ready), 64'(exp_rdy));
    exp_rv = '0;
    exp_orph = 1'b0;
    rkey = int'(resp_mshrid);
    if (resp_valid) begin
      if (owner.exists(rkey)) exp_rv[owner[rkey]] = 1'b1;
      else exp_orph = 1'b1;
      chk("resp_bcast_data", rsink_data[rkey % NS], resp_data);
      chk("resp_bcast_mshrid", 64'(rsink_mshrid[(rkey + 1) % NS]), 64'(resp_mshrid));
    end
    chk("resp_sink_valid", 64'(rsink_valid), 64'(exp_rv));
    chk("resp_orphan", 64'(orphan), 64'(exp_orph));
    chk("outstanding_cnt", 64'(cnt), 64'(owner.num()));
    dut_hs = -1;
    for (int i = 0; i < NS; i++) if (src_ready[i]) dut_hs = i;
    hs_src = (ev && sink_ready) ? g : -1;
    @(posedge clk);
    if (resp_valid && owner.exists(rkey)) owner.delete(rkey);
    if (hs_src >= 0) begin
      owner[int'(src_mshrid[g])] = g;
      m_last   = g;
      m_locked = 1'b0;
    end else if (ev) begin
      m_locked   = 1'b1;
      m_lock_src = g;
    end
    #1;
  endtask

  task automatic set_src(input int i, input int m);
    src_valid[i]    = 1'b1;
    src_mshrid[i]   = 8'(m);
    src_req_type[i] = 4'($urandom_range(0, 15));
    src_address[i]  = {8'($urandom), 32'($urandom)};
    src_size[i]     = 3'($urandom_range(0, 7));
    src_homeid[i]   = 16'($urandom);
    src_wmask[i]    = 8'($urandom);
    src_d0[i]       = {$urandom, $urandom};
    src_d1[i]       = {$urandom, $urandom};
  endtask

  task automatic drop_hs();
    if (hs_src >= 0) src_valid[hs_src] = 1'b0;
  endtask

  task automatic send_resp(input int m);
    resp_valid  = 1'b1;
    resp_mshrid = 8'(m);
    resp_data   = {$urandom, $urandom};
  endtask

  task automatic rand_stim();
    int keys[$];
    for (int i = 0; i < NS; i++) begin
      if (!(src_valid[i] && hs_src != i)) begin
        if ($urandom_range(0, 99) < 60) set_src(i, $urandom_range(0, 15));
        else src_valid[i] = 1'b0;
      end
    end
    sink_ready = ($urandom_range(0, 99) < 70);
    resp_valid = 1'b0;
    if ($urandom_range(0, 99) < 40) begin
      foreach (owner[k]) keys.push_back(k);
      if (keys.size() > 0 && $urandom_range(0, 99) < 85)
        send_resp(keys[$urandom_range(0, keys.size() - 1)]);
      else
        send_resp($urandom_range(0, 15));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sink_valid"}, 64'(sink_valid), 64'd0);
    chk({tag, "_src_ready"}, 64'(src_ready), 64'd0);
    chk({tag, "_resp_valid"}, 64'(rsink_valid), 64'd0);
    chk({tag, "_orphan"}, 64'(orphan), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
  endtask

  initial begin
    int ord[4];
    src_valid = '0;
    for (int i = 0; i < NS; i++) begin
      set_src(i, 0);
      src_valid[i] = 1'b0;
    end
    sink_ready  = 1'b0;
    resp_valid  = 1'b0;
    resp_mshrid = '0;
    resp_data   = '0;
    hs_src      = -1;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset and first grant: sources 0..3 with mshrid 1..4.
    for (int i = 0; i < NS; i++) set_src(i, i + 1);
    sink_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("first_grant", 64'(dut_hs), 64'(k));
      drop_hs();
    end
    chk("cnt_full", 64'(cnt), 64'd4);
    set_src(0, 5);
    #1;
    chk("full_sink_valid", 64'(sink_valid), 64'd0);
    cycle();
    src_valid[0] = 1'b0;

    // Out-of-order responses.
    ord = '{3, 1, 4, 2};
    for (int k = 0; k < 4; k++) begin
      send_resp(ord[k]);
      #1;
      chk("ooo_resp_route", 64'(rsink_valid), 64'(1 << (ord[k] - 1)));
      cycle();
      chk("ooo_cnt", 64'(cnt), 64'(3 - k));
    end
    resp_valid = 1'b0;

    // Orphan response.
    send_resp(9);
    #1;
    chk("orphan_hit", 64'(orphan), 64'd1);
    chk("orphan_no_sink", 64'(rsink_valid), 64'd0);
    cycle();
    resp_valid = 1'b0;
    #1;
    chk("orphan_pulse_end", 64'(orphan), 64'd0);
    chk("orphan_cnt", 64'(cnt), 64'd0);

    // Backpressure lock: source 1 granted and stalled while source 2 waits.
    set_src(1, 10);
    set_src(2, 11);
    sink_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("bp_payload", 64'(sink_mshrid), 64'd10);
      chk("bp_src2_ready", 64'(src_ready[2]), 64'd0);
    end
    sink_ready = 1'b1;
    cycle();
    chk("bp_hs1", 64'(dut_hs), 64'd1);
    drop_hs();
    cycle();
    chk("bp_hs2", 64'(dut_hs), 64'd2);
    drop_hs();
    send_resp(10); cycle();
    send_resp(11); cycle();
    resp_valid = 1'b0;

    // Duplicate tag stall.
    set_src(0, 7);
    cycle();
    chk("dup_first", 64'(dut_hs), 64'd0);
    drop_hs();
    set_src(1, 7);
    repeat (3) begin
      cycle();
      chk("dup_stall", 64'(dut_hs), 64'(-1));
    end
    send_resp(7);
    cycle();
    chk("dup_free_cycle", 64'(dut_hs), 64'(-1));
    resp_valid = 1'b0;
    cycle();
    chk("dup_grant", 64'(dut_hs), 64'd1);
    drop_hs();
    send_resp(7); cycle();
    resp_valid = 1'b0;

    // Asynchronous reset with three outstanding.
    for (int i = 0; i < 3; i++) set_src(i, 20 + i);
    for (int k = 0; k < 3; k++) begin
      cycle();
      drop_hs();
    end
    chk("pre_reset_cnt", 64'(cnt), 64'd3);
    #2;
    src_valid = '0;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int m = 20; m < 23; m++) begin
      send_resp(m);
      #1;
      chk("post_rst_orphan", 64'(orphan), 64'd1);
      cycle();
    end
    resp_valid = 1'b0;
    hs_src = -1;

    // Randomized traffic.
    rand_stim();
    repeat (3000) begin
      cycle();
      rand_stim();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
